// File: rtl/is_array_scheduler.sv
// Sequences one systolic-array job: load ARRAY_WIDTH input beats, stream num_vec weight
// vectors, then drain the pipeline until every accepted vector has produced its aligned psum.
module is_array_scheduler #(
  parameter int unsigned ARRAY_HEIGHT = 4,
  parameter int unsigned ARRAY_WIDTH  = 4,
  parameter int unsigned PIPE_LATENCY = ARRAY_HEIGHT + ARRAY_WIDTH,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_vec,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic                 out_ready,
  output logic                 input_en,
  output logic                 process_en,
  output logic                 psum_valid
);

  localparam int unsigned LdW = (ARRAY_WIDTH > 1) ? $clog2(ARRAY_WIDTH) : 1;
  localparam logic [LdW-1:0] LdLast = LdW'(ARRAY_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StStream, StDrain} state_e;

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    num_vec_q, num_vec_d;
  logic [CNT_WIDTH-1:0]    vec_cnt_q, vec_cnt_d;
  logic [LdW-1:0]          load_cnt_q, load_cnt_d;
  logic [PIPE_LATENCY-1:0] valid_sr_q, valid_sr_d;
  logic [PIPE_LATENCY-1:0] accept_vec;
  logic                    accept;

  always_comb begin
    state_d    = state_q;
    num_vec_d  = num_vec_q;
    vec_cnt_d  = vec_cnt_q;
    load_cnt_d = load_cnt_q;
    valid_sr_d = valid_sr_q;
    in_ready   = 1'b0;
    input_en   = 1'b0;
    w_ready    = 1'b0;
    process_en = 1'b0;
    accept     = 1'b0;
    done       = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StLoad;
          num_vec_d  = num_vec;
          vec_cnt_d  = '0;
          load_cnt_d = '0;
          valid_sr_d = '0;
        end
      end
      StLoad: begin
        in_ready = 1'b1;
        input_en = in_valid;
        if (in_valid) begin
          load_cnt_d = load_cnt_q + LdW'(1);
          if (load_cnt_q == LdLast) begin
            state_d = (num_vec_q == '0) ? StDrain : StStream;
          end
        end
      end
      StStream: begin
        w_ready    = out_ready;
        process_en = w_valid & out_ready;
        accept     = process_en;
        if (accept) begin
          vec_cnt_d = vec_cnt_q + CNT_WIDTH'(1);
          // Compare against num_vec-1 so the counter never has to reach 2^CNT_WIDTH.
          if (vec_cnt_q == num_vec_q - CNT_WIDTH'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        process_en = out_ready;
        if (valid_sr_q == '0) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    accept_vec    = '0;
    accept_vec[0] = accept;
    // The in-flight tracker moves in lockstep with the array, so it freezes on a stall.
    if (process_en) begin
      valid_sr_d = (valid_sr_q << 1) | accept_vec;
    end
  end

  assign busy       = (state_q != StIdle);
  assign psum_valid = process_en & valid_sr_q[PIPE_LATENCY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      num_vec_q  <= '0;
      vec_cnt_q  <= '0;
      load_cnt_q <= '0;
      valid_sr_q <= '0;
    end else begin
      state_q    <= state_d;
      num_vec_q  <= num_vec_d;
      vec_cnt_q  <= vec_cnt_d;
      load_cnt_q <= load_cnt_d;
      valid_sr_q <= valid_sr_d;
    end
  end

endmodule

// File: doc/is_array_scheduler.md
IS_ARRAY_SCHEDULER -- requirements
Module: is_array_scheduler

Interface
REQ-001 SHALL have parameter ARRAY_HEIGHT, default 4: array rows; sets psum vector count.
REQ-002 SHALL have parameter ARRAY_WIDTH, default 4: array columns; sets number of input-load beats.
REQ-003 SHALL have parameter PIPE_LATENCY, default ARRAY_HEIGHT+ARRAY_WIDTH: enabled cycles from weight vector entry to aligned psum_out.
REQ-004 SHALL have parameter CNT_WIDTH, default 16: width of the weight-vector count.
REQ-005 SHALL use one clock and an asynchronous, active-low reset; ports below.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 start  input  1  begin job; sampled only in IDLE.
REQ-009 num_vec  input  CNT_WIDTH  weight vectors to stream; captured with start.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done  output  1  one-cycle pulse on DRAIN->IDLE.
REQ-012 in_valid / in_ready  input / output  1 / 1  input-vector handshake.
REQ-013 w_valid / w_ready  input / output  1 / 1  weight-vector handshake.
REQ-014 out_ready  input  1  consumer can accept psum.
REQ-015 input_en  output  1  array input-shift enable.
REQ-016 process_en  output  1  array compute/skew enable.
REQ-017 psum_valid  output  1  array psum_out is a valid aligned result.

Function
REQ-018 SHALL implement FSM IDLE, LOAD, STREAM, DRAIN.
REQ-019 IDLE: start=1 -> LOAD; capture num_vec; clear load and stream counters.
REQ-020 LOAD: in_ready=1; input_en = in_valid; each in_valid beat increments load count; the ARRAY_WIDTH-th beat -> STREAM on the next cycle.
REQ-021 STREAM: w_ready = out_ready; process_en = w_valid & out_ready; each such beat is an accepted vector; the beat accepting vector num_vec -> DRAIN.
REQ-022 num_vec=0 captured: LOAD completes, then go directly to DRAIN (no STREAM cycle); DRAIN then completes immediately.
REQ-023 DRAIN: process_en = out_ready; stay until no accepted vector remains in flight; then -> IDLE with done pulse.
REQ-024 SHALL track in-flight vectors with a PIPE_LATENCY-deep valid shift register that advances only when process_en=1; bit 0 is set on accepted beats, otherwise 0.
REQ-025 psum_valid SHALL equal the shift-register output bit while process_en=1 and be 0 otherwise; exactly num_vec psum_valid pulses per job.
REQ-026 out_ready=0 SHALL force process_en=0 and w_ready=0 (array frozen, no result lost).
REQ-027 input_en and process_en SHALL never be high in the same cycle.
REQ-028 in_ready=0 and w_ready=0 outside LOAD and STREAM respectively.
REQ-029 start while busy SHALL be ignored.
REQ-030 Counters SHALL not wrap: num_vec = 2^CNT_WIDTH-1 completes correctly.

Reset
REQ-031 rst_n=0 SHALL asynchronously force IDLE, clear counters and shift register; all outputs 0 during reset.
REQ-032 Reset mid-job SHALL abort the job with no done pulse; the next start after release runs normally.

Verification
REQ-033 Basic job, num_vec=3, all valid/ready high: 4 input_en cycles, 3 process_en STREAM cycles, psum_valid on enabled cycles 8-10 after the first weight beat, then done.
REQ-034 out_ready low for 5 cycles mid-DRAIN: process_en=0 during the stall, psum_valid resumes afterward; total 3 pulses, no drops.
REQ-035 w_valid toggling 1,0,1,0 in STREAM: process_en only on valid beats; psum_valid count equals num_vec.
REQ-036 num_vec=0: 4 load beats, then done with no process_en cycle and zero psum_valid pulses.
REQ-037 rst_n asserted in STREAM after 2 vectors: outputs 0 immediately, no done pulse; a restarted job with num_vec=1 gives exactly 1 psum_valid.
REQ-038 start pulsed in STREAM: ignored, with no change to the counts or timing of the current job.
